destino_fifos: RTL



---
 rtl/destino_fifos_pkg.sv | 18 +
 rtl/destino_fifos_fifo_sync.sv | 66 ++++++
 rtl/destino_fifos.sv | 70 +++++++
 3 files changed

// File: rtl/destino_fifos_pkg.sv
// Shared constants for the routing path: word width, FIFO depth,
// almost-full threshold and the pointer-width helper.
package destino_fifos_pkg;

    localparam int DATA_W_DEF    = 6;
    localparam int DEPTH_DEF     = 4;
    localparam int AF_THRESH_DEF = 3;

    function automatic int log2c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/destino_fifos_fifo_sync.sv
// Single-clock FIFO with registered read data, almost-full pause and
// a one-cycle error pulse on overflow or underflow attempts.
module fifo_sync
    import destino_fifos_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              push,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              pause,
    output logic              err_pulse
);

    localparam int PW = log2c(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] THR  = CW'(AF_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              push_ok;
    logic              pop_ok;

    // A pop frees the slot, so a full FIFO can still take a word that cycle.
    assign pop_ok    = pop && (count != '0);
    assign push_ok   = push && ((count != FULL) || pop_ok);
    assign err_pulse = (push && !push_ok) || (pop && !pop_ok);
    assign empty     = (count == '0);
    assign pause     = (count >= THR);

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok) begin
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/destino_fifos.sv
// Destination buffering after the routing arbiter: two independent
// FIFOs with pause back-pressure and a shared sticky error flag.
module destino_fifos
    import destino_fifos_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_THRESH = AF_THRESH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] D0_in,
    input  logic              D0_push,
    input  logic [DATA_W-1:0] D1_in,
    input  logic              D1_push,
    input  logic              D0_pop,
    input  logic              D1_pop,
    output logic [DATA_W-1:0] D0_data_out,
    output logic [DATA_W-1:0] D1_data_out,
    output logic              D0_empty,
    output logic              D1_empty,
    output logic              D0_pause,
    output logic              D1_pause,
    output logic              error_out
);

    logic err0;
    logic err1;

    fifo_sync #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_d0 (
        .clk       (clk),
        .reset     (reset),
        .din       (D0_in),
        .push      (D0_push),
        .pop       (D0_pop),
        .dout      (D0_data_out),
        .empty     (D0_empty),
        .pause     (D0_pause),
        .err_pulse (err0)
    );

    fifo_sync #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_d1 (
        .clk       (clk),
        .reset     (reset),
        .din       (D1_in),
        .push      (D1_push),
        .pop       (D1_pop),
        .dout      (D1_data_out),
        .empty     (D1_empty),
        .pause     (D1_pause),
        .err_pulse (err1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            error_out <= 1'b0;
        end else if (err0 || err1) begin
            error_out <= 1'b1;
        end
    end

endmodule
